// File: rtl/scene_pkg.sv
// Shared constants and FSM state encoding for the scene fade controller.
package scene_pkg;

    localparam int SCENE_W_DEF = 3;
    localparam int LEVEL_W_DEF = 4;
    localparam int COLOR_W_DEF = 8;

    function automatic int level_max(input int level_w);
        return (2 ** level_w) - 1;
    endfunction

    localparam int LEVEL_MAX = level_max(LEVEL_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWAP     = 2'd2,
        ST_FADE_IN  = 2'd3
    } fade_state_e;

endpackage

// File: rtl/fade_scaler.sv
// Scales one colour channel by (level+1)/2**LEVEL_W; level 0 forces black.
module fade_scaler #(
    parameter int COLOR_W = 8,
    parameter int LEVEL_W = 4
) (
    input  logic [COLOR_W-1:0] color,
    input  logic [LEVEL_W-1:0] level,
    output logic [COLOR_W-1:0] scaled
);

    localparam int PROD_W = COLOR_W + LEVEL_W + 1;

    logic [PROD_W-1:0] product;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        product = PROD_W'(color) * (PROD_W'(level) + PROD_W'(1));
        scaled  = (level == '0) ? '0 : COLOR_W'(product >> LEVEL_W);
    end

endmodule

// File: rtl/scene_fade_ctrl.sv
// Frame-synchronous fade-out / swap / fade-in sequencer for scene changes,
// plus the registered pixel dimmer that applies the current fade level.
module scene_fade_ctrl
    import scene_pkg::*;
#(
    parameter int SCENE_W         = SCENE_W_DEF,
    parameter int LEVEL_W         = LEVEL_W_DEF,
    parameter int FRAMES_PER_STEP = 2,
    parameter int COLOR_W         = COLOR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SCENE_W-1:0]   scene_req,
    input  logic                 frame_start,
    input  logic                 pix_valid_in,
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic [SCENE_W-1:0]   scene_active,
    output logic                 scene_changed,
    output logic [LEVEL_W-1:0]   fade_level,
    output logic                 busy,
    output logic                 pix_valid_out,
    output logic [3*COLOR_W-1:0] rgb_out
);

    localparam int                 CNT_W    = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(level_max(LEVEL_W));

    fade_state_e          state;
    logic [SCENE_W-1:0]   target;
    logic [CNT_W-1:0]     frame_cnt;
    logic                 step;
    logic [3*COLOR_W-1:0] scaled_rgb;

    assign step = frame_start && (frame_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            scene_active  <= '0;
            target        <= '0;
            fade_level    <= LVL_MAX;
            frame_cnt     <= '0;
            scene_changed <= 1'b0;
            busy          <= 1'b0;
        end else begin
            scene_changed <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start && (scene_req != scene_active)) begin
                        state     <= ST_FADE_OUT;
                        busy      <= 1'b1;
                        target    <= scene_req;
                        frame_cnt <= '0;
                    end
                end
                ST_FADE_OUT: begin
                    // Latest request wins until the swap happens.
                    target <= scene_req;
                    if (step) begin
                        frame_cnt <= '0;
                        if (fade_level != '0) fade_level <= fade_level - LEVEL_W'(1);
                        if (fade_level <= LEVEL_W'(1)) state <= ST_SWAP;
                    end else if (frame_start) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                ST_SWAP: begin
                    scene_active  <= target;
                    scene_changed <= 1'b1;
                    frame_cnt     <= '0;
                    state         <= ST_FADE_IN;
                end
                ST_FADE_IN: begin
                    if (step) begin
                        frame_cnt <= '0;
                        if (fade_level != LVL_MAX) fade_level <= fade_level + LEVEL_W'(1);
                        if (fade_level >= LVL_MAX - LEVEL_W'(1)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (frame_start) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_channel
        fade_scaler #(
            .COLOR_W (COLOR_W),
            .LEVEL_W (LEVEL_W)
        ) u_scaler (
            .color  (rgb_in[ch*COLOR_W +: COLOR_W]),
            .level  (fade_level),
            .scaled (scaled_rgb[ch*COLOR_W +: COLOR_W])
        );
    end

    // Pixel path runs every cycle using the level held before this edge's FSM update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid_out <= 1'b0;
            rgb_out       <= '0;
        end else begin
            pix_valid_out <= pix_valid_in;
            rgb_out       <= scaled_rgb;
        end
    end

endmodule
